// File: rtl/stereo_proc_stream.sv
// Joint-stereo stage: per-sample mid/side, intensity or passthrough on a
// 3-stage valid/ready pipeline with saturating fixed-point products.
module stereo_proc_stream #(
   parameter int W              = 32,
   parameter int FRAC           = 30,
   parameter int SAMPLES_PER_GR = 576,
   parameter int IDXW           = $clog2(SAMPLES_PER_GR + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          mode_in,
   input  logic [1:0]          mode_ext_in,
   input  logic [IDXW-1:0]     is_bound_in,
   input  logic signed [W-1:0] ch1_in,
   input  logic signed [W-1:0] ch2_in,
   input  logic [2:0]          is_pos_in,
   input  logic                in_valid,
   output logic                in_ready,
   output logic signed [W-1:0] ch1_out,
   output logic signed [W-1:0] ch2_out,
   output logic                gr_out,
   output logic                last_out,
   output logic                sat_out,
   output logic                out_valid,
   input  logic                out_ready
);
   localparam int CW = FRAC + 2;
   localparam int PW = 2 * W + 2;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SAMPLES_PER_GR - 1);
   localparam logic [1:0] SEL_PASS = 2'd0;
   localparam logic [1:0] SEL_MS   = 2'd1;
   localparam logic [1:0] SEL_IS   = 2'd2;
   localparam logic signed [PW-1:0] MAX_P = $signed({{(PW-W+1){1'b0}}, {(W-1){1'b1}}});
   localparam logic signed [PW-1:0] MIN_P = $signed({{(PW-W+1){1'b1}}, {(W-1){1'b0}}});

   // Coefficients are tabulated in Q30 and rescaled (rounded) to Q(FRAC).
   function automatic logic signed [CW-1:0] scale_coef(input logic [31:0] c30);
      logic signed [63:0] v;
      int sh;
      v  = $signed({32'd0, c30});
      sh = 30 - FRAC;
      if (sh > 0)
         v = (v + (64'sd1 <<< (sh - 1))) >>> sh;
      else if (sh < 0)
         v = v <<< (-sh);
      return v[CW-1:0];
   endfunction

   function automatic logic signed [CW-1:0] is_coef(input logic [2:0] p);
      logic [31:0] c30;
      case (p)
         3'd0:    c30 = 32'h0000_0000;
         3'd1:    c30 = 32'h0D86_5839;
         3'd2:    c30 = 32'h176C_F55C;
         3'd3:    c30 = 32'h2000_0000;
         3'd4:    c30 = 32'h2893_0A4A;
         3'd5:    c30 = 32'h3279_A74E;
         default: c30 = 32'h4000_0000;
      endcase
      return scale_coef(c30);
   endfunction

   function automatic logic signed [W-1:0] shift_sat(input logic signed [PW-1:0] prod,
                                                     output logic sat);
      logic signed [PW-1:0] v;
      v = prod >>> FRAC;
      if (v > MAX_P) begin
         sat = 1'b1;
         shift_sat = MAX_P[W-1:0];
      end else if (v < MIN_P) begin
         sat = 1'b1;
         shift_sat = MIN_P[W-1:0];
      end else begin
         sat = 1'b0;
         shift_sat = v[W-1:0];
      end
   endfunction

   localparam logic signed [CW-1:0] K_MS  = scale_coef(32'h2D41_3CCD);
   localparam logic signed [CW-1:0] K_ONE = scale_coef(32'h4000_0000);

   logic                en, accept, first;
   logic [IDXW-1:0]     idx, bound_l, bound_e;
   logic                gr;
   logic [1:0]          mode_l, ext_l, mode_e, ext_e, sel_in;

   assign en       = !out_valid | out_ready;
   assign in_ready = en;
   assign accept   = in_valid & en;
   assign first    = (idx == '0);

   // Beat 0 of a granule already uses the side info it is latching.
   always_comb begin
      mode_e  = first ? mode_in     : mode_l;
      ext_e   = first ? mode_ext_in : ext_l;
      bound_e = first ? is_bound_in : bound_l;
      sel_in  = SEL_PASS;
      if (mode_e == 2'b01 && ext_e[0] && idx >= bound_e && is_pos_in != 3'd7)
         sel_in = SEL_IS;
      else if (mode_e == 2'b01 && ext_e[1])
         sel_in = SEL_MS;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx     <= '0;
         gr      <= 1'b0;
         mode_l  <= 2'b00;
         ext_l   <= 2'b00;
         bound_l <= '0;
      end else if (accept) begin
         if (first) begin
            mode_l  <= mode_in;
            ext_l   <= mode_ext_in;
            bound_l <= is_bound_in;
         end
         if (idx == LAST_IDX) begin
            idx <= '0;
            gr  <= ~gr;
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

   // S1: input capture and mode decode
   logic                vld_p0, gr_p0, last_p0;
   logic signed [W-1:0] ch1_p0, ch2_p0;
   logic [2:0]          pos_p0;
   logic [1:0]          sel_p0;

   always_ff @(posedge clk) begin
      if (rst)
         vld_p0 <= 1'b0;
      else if (en)
         vld_p0 <= in_valid;
   end

   always_ff @(posedge clk) begin
      if (en) begin
         ch1_p0  <= ch1_in;
         ch2_p0  <= ch2_in;
         pos_p0  <= is_pos_in;
         sel_p0  <= sel_in;
         gr_p0   <= gr;
         last_p0 <= (idx == LAST_IDX);
      end
   end

   // S2: pre-sum and multiply; passthrough multiplies by unity
   logic signed [W:0]    ext1, ext2, a_l, a_r;
   logic signed [CW-1:0] c_l, c_r;
   logic                 vld_p1, gr_p1, last_p1;
   logic signed [PW-1:0] prod_l_p1, prod_r_p1;

   always_comb begin
      ext1 = {ch1_p0[W-1], ch1_p0};
      ext2 = {ch2_p0[W-1], ch2_p0};
      a_l  = ext1;
      a_r  = ext2;
      c_l  = K_ONE;
      c_r  = K_ONE;
      case (sel_p0)
         SEL_MS: begin
            a_l = ext1 + ext2;
            a_r = ext1 - ext2;
            c_l = K_MS;
            c_r = K_MS;
         end
         SEL_IS: begin
            a_r = ext1;
            c_l = is_coef(pos_p0);
            c_r = is_coef(3'd6 - pos_p0);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         vld_p1 <= 1'b0;
      else if (en)
         vld_p1 <= vld_p0;
   end

   always_ff @(posedge clk) begin
      if (en) begin
         prod_l_p1 <= PW'(a_l) * PW'(c_l);
         prod_r_p1 <= PW'(a_r) * PW'(c_r);
         gr_p1     <= gr_p0;
         last_p1   <= last_p0;
      end
   end

   // S3: shift, saturate and output register
   logic signed [W-1:0] res_l, res_r;
   logic                sat_l, sat_r;

   always_comb begin
      res_l = shift_sat(prod_l_p1, sat_l);
      res_r = shift_sat(prod_r_p1, sat_r);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         ch1_out   <= '0;
         ch2_out   <= '0;
         gr_out    <= 1'b0;
         last_out  <= 1'b0;
         sat_out   <= 1'b0;
      end else if (en) begin
         out_valid <= vld_p1;
         ch1_out   <= res_l;
         ch2_out   <= res_r;
         gr_out    <= gr_p1;
         last_out  <= last_p1;
         sat_out   <= sat_l | sat_r;
      end
   end

endmodule

// File: tb/tb_stereo_proc_stream.sv
// Bench for stereo_proc_stream: directed beats, a spec-level reference model
// with a per-cycle scoreboard, plus literal expectations.
module tb_stereo_proc_stream;
   localparam int W    = 32;
   localparam int FRAC = 30;
   localparam int SPG  = 576;
   localparam int IDXW = 10;

   logic               clk = 1'b0;
   logic               rst;
   logic [1:0]         mode_in, mode_ext_in;
   logic [IDXW-1:0]    is_bound_in;
   logic signed [31:0] ch1_in, ch2_in;
   logic [2:0]         is_pos_in;
   logic               in_valid, in_ready;
   logic signed [31:0] ch1_out, ch2_out;
   logic               gr_out, last_out, sat_out, out_valid, out_ready;

   stereo_proc_stream #(.W(W), .FRAC(FRAC), .SAMPLES_PER_GR(SPG), .IDXW(IDXW)) dut (
      .clk(clk), .rst(rst), .mode_in(mode_in), .mode_ext_in(mode_ext_in),
      .is_bound_in(is_bound_in), .ch1_in(ch1_in), .ch2_in(ch2_in),
      .is_pos_in(is_pos_in), .in_valid(in_valid), .in_ready(in_ready),
      .ch1_out(ch1_out), .ch2_out(ch2_out), .gr_out(gr_out), .last_out(last_out),
      .sat_out(sat_out), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", nm, act, exp);
   endtask

   // Reference model: spec formulas in wide integer arithmetic
   typedef struct packed {
      logic [31:0] l;
      logic [31:0] r;
      logic        sat;
      logic        gr;
      logic        last;
   } exp_t;

   exp_t            q[$];
   int              m_idx = 0;
   logic            m_gr = 1'b0;
   logic [1:0]      m_mode = 2'b00, m_ext = 2'b00;
   logic [IDXW-1:0] m_bound = '0;

   localparam logic signed [127:0] K = 128'sh2D413CCD;

   function automatic logic signed [127:0] kl_of(input int p);
      case (p)
         0:       return 128'sh0;
         1:       return 128'sh0D865839;
         2:       return 128'sh176CF55C;
         3:       return 128'sh20000000;
         4:       return 128'sh28930A4A;
         5:       return 128'sh3279A74E;
         default: return 128'sh40000000;
      endcase
   endfunction

   function automatic logic [31:0] clamp(input logic signed [127:0] v, output logic s);
      s = (v > 128'sh7FFFFFFF) || (v < -128'sh80000000);
      if (!s) return v[31:0];
      return (v > 0) ? 32'h7FFFFFFF : 32'h80000000;
   endfunction

   task automatic model_accept(input logic signed [31:0] a, input logic signed [31:0] b,
                               input logic [2:0] p);
      logic signed [127:0] av, bv, lv, rv;
      logic s1, s2;
      exp_t e;
      if (m_idx == 0) begin
         m_mode  = mode_in;
         m_ext   = mode_ext_in;
         m_bound = is_bound_in;
      end
      av = 128'(a);
      bv = 128'(b);
      if (m_mode == 2'b01 && m_ext[0] && m_idx >= int'(m_bound) && p != 3'd7) begin
         lv = (av * kl_of(int'(p))) >>> 30;
         rv = (av * kl_of(6 - int'(p))) >>> 30;
      end else if (m_mode == 2'b01 && m_ext[1]) begin
         lv = ((av + bv) * K) >>> 30;
         rv = ((av - bv) * K) >>> 30;
      end else begin
         lv = av;
         rv = bv;
      end
      e.l    = clamp(lv, s1);
      e.r    = clamp(rv, s2);
      e.sat  = s1 | s2;
      e.gr   = m_gr;
      e.last = (m_idx == SPG - 1);
      q.push_back(e);
      m_idx++;
      if (m_idx == SPG) begin
         m_idx = 0;
         m_gr  = ~m_gr;
      end
   endtask

   logic [31:0] rec_ch1 [0:1023];
   logic        rec_gr  [0:1023];
   logic        rec_last[0:1023];
   int          out_cnt = 0;

   // Scoreboard: sampled at negedge, transfers happen at the following posedge
   initial begin
      logic        stall_prev, rst_prev;
      logic [31:0] s_ch1, s_ch2;
      logic [2:0]  s_flags;
      exp_t        e;
      stall_prev = 1'b0;
      rst_prev   = 1'b1;
      s_ch1 = '0; s_ch2 = '0; s_flags = '0;
      forever begin
         @(negedge clk);
         chk1("in_ready_rule", in_ready, !out_valid || out_ready);
         if (stall_prev && !rst_prev) begin
            chk("stall_ch1", ch1_out, s_ch1);
            chk("stall_ch2", ch2_out, s_ch2);
            chk("stall_flags", {29'd0, gr_out, last_out, sat_out}, {29'd0, s_flags});
         end
         if (out_valid && out_ready) begin
            chk1("out_expected", q.size() != 0, 1'b1);
            if (q.size() != 0) begin
               e = q.pop_front();
               chk("out_ch1", ch1_out, e.l);
               chk("out_ch2", ch2_out, e.r);
               chk1("out_sat", sat_out, e.sat);
               chk1("out_gr", gr_out, e.gr);
               chk1("out_last", last_out, e.last);
            end
            if (out_cnt < 1024) begin
               rec_ch1[out_cnt]  = ch1_out;
               rec_gr[out_cnt]   = gr_out;
               rec_last[out_cnt] = last_out;
            end
            out_cnt++;
         end
         stall_prev = out_valid && !out_ready;
         rst_prev   = rst;
         s_ch1      = ch1_out;
         s_ch2      = ch2_out;
         s_flags    = {gr_out, last_out, sat_out};
         if (rst) begin
            q.delete();
            m_idx = 0; m_gr = 1'b0; m_mode = 2'b00; m_ext = 2'b00; m_bound = '0;
            out_cnt = 0;
         end else if (in_valid && in_ready) begin
            model_accept(ch1_in, ch2_in, is_pos_in);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] p);
      int  n;
      logic acc;
      n = 0;
      ch1_in = a; ch2_in = b; is_pos_in = p; in_valid = 1'b1;
      do begin
         @(negedge clk);
         acc = in_ready && !rst;
         @(posedge clk); #1;
         n++;
      end while (!acc && n < 100);
      if (!acc) chk1("send_timeout", acc, 1'b1);
      in_valid = 1'b0;
   endtask

   task automatic expect_out(input string nm, input logic [31:0] e1, input logic [31:0] e2,
                             input logic es, output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 20);
      chk1({nm, "_valid"}, out_valid, 1'b1);
      chk({nm, "_ch1"}, ch1_out, e1);
      chk({nm, "_ch2"}, ch2_out, e2);
      chk1({nm, "_sat"}, sat_out, es);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic set_side(input logic [1:0] m, input logic [1:0] x, input logic [IDXW-1:0] bd);
      mode_in = m; mode_ext_in = x; is_bound_in = bd;
   endtask

   initial begin
      int lat, nlast, lastpos;
      rst = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
      ch1_in = '0; ch2_in = '0; is_pos_in = '0;
      set_side(2'b00, 2'b00, '0);
      repeat (3) @(posedge clk);
      #1;
      chk1("rst_out_valid", out_valid, 1'b0);
      chk("rst_ch1", ch1_out, 32'h0);
      chk("rst_ch2", ch2_out, 32'h0);
      chk("rst_flags", {29'd0, gr_out, last_out, sat_out}, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk1("in_ready_after_rst", in_ready, 1'b1);
      @(posedge clk); #1;

      // mid/side and latency
      set_side(2'b01, 2'b10, '0);
      send(32'h1000_0000, 32'h0, 3'd0);
      expect_out("ms", 32'h0B50_4F33, 32'h0B50_4F33, 1'b0, lat);
      chk("ms_latency", lat, 3);

      // intensity
      do_reset();
      set_side(2'b01, 2'b01, '0);
      send(32'h2000_0000, 32'h0, 3'd3);
      expect_out("is3", 32'h1000_0000, 32'h1000_0000, 1'b0, lat);
      send(32'h2000_0000, 32'h1111_1111, 3'd0);
      expect_out("is0", 32'h0, 32'h2000_0000, 1'b0, lat);
      send(32'h1234_5678, 32'h0ABC_DEF0, 3'd7);
      expect_out("is7", 32'h1234_5678, 32'h0ABC_DEF0, 1'b0, lat);

      // saturation
      do_reset();
      set_side(2'b01, 2'b10, '0);
      send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 3'd0);
      expect_out("sat_pos", 32'h7FFF_FFFF, 32'h0, 1'b1, lat);
      send(32'h8000_0000, 32'h8000_0000, 3'd0);
      expect_out("sat_neg", 32'h8000_0000, 32'h0, 1'b1, lat);

      // backpressure
      do_reset();
      set_side(2'b00, 2'b00, '0);
      fork
         begin
            for (int i = 0; i < 10; i++) send(32'(100 + i), 32'(200 + i), 3'd0);
         end
         begin
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (5) begin
               @(negedge clk);
               chk1("bp_in_ready", in_ready, 1'b0);
               chk1("bp_out_valid", out_valid, 1'b1);
            end
            @(posedge clk); #1 out_ready = 1'b1;
         end
      join
      repeat (8) @(negedge clk);
      chk("bp_count", out_cnt, 10);
      chk("bp_first", rec_ch1[0], 32'd100);
      chk("bp_last", rec_ch1[9], 32'd109);
      chk("bp_queue_empty", q.size(), 0);
      @(posedge clk); #1;

      // granule wrap; side info change at beat 300 must wait for beat 576
      do_reset();
      set_side(2'b01, 2'b10, '0);
      for (int i = 0; i < SPG + 4; i++) begin
         if (i == 300) set_side(2'b00, 2'b00, 10'd5);
         send(32'h0000_1000, 32'h0, 3'd0);
      end
      repeat (6) @(negedge clk);
      nlast = 0; lastpos = -1;
      for (int i = 0; i < SPG + 4; i++)
         if (rec_last[i]) begin nlast++; lastpos = i; end
      chk("wrap_count", out_cnt, SPG + 4);
      chk("wrap_nlast", nlast, 1);
      chk("wrap_lastpos", lastpos, SPG - 1);
      chk1("wrap_gr575", rec_gr[SPG-1], 1'b0);
      chk1("wrap_gr576", rec_gr[SPG], 1'b1);
      chk("wrap_ch1_575", rec_ch1[SPG-1], 32'h0000_0B50);
      chk("wrap_ch1_300", rec_ch1[300], 32'h0000_0B50);
      chk("wrap_ch1_576", rec_ch1[SPG], 32'h0000_1000);
      @(posedge clk); #1;

      // reset with beats in flight (parity is 1 here)
      for (int i = 0; i < 3; i++) send(32'h0000_2000, 32'h0, 3'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk1("rstfly_out_valid", out_valid, 1'b0);
      @(posedge clk); #1;
      set_side(2'b01, 2'b01, '0);
      rst = 1'b0;
      send(32'h2000_0000, 32'h0, 3'd3);
      expect_out("rstfly_is", 32'h1000_0000, 32'h1000_0000, 1'b0, lat);
      repeat (2) @(negedge clk);
      chk1("rstfly_gr_rec", rec_gr[0], 1'b0);
      chk("rstfly_queue_empty", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
